crossbar_rr_arb_seq: RTL and testbench

Parametrised N-input, M-output crossbar with per-output round-robin arbitration and valid/ready flow control on both sides. It replaces externally supplied one-hot routing commands with a binary destination field carried alongside each input word, and it resolves contention in hardware. It sits between producer lanes and consumer lanes in the distribution network and has one registered output stage per output port.

---
 rtl/crossbar_rr_arb_seq.sv | 132 +++++++++++++
 tb/tb_crossbar_rr_arb_seq.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_rr_arb_seq.sv
// N-input, M-output crossbar with binary destination routing and per-output round-robin arbitration.
// Each output owns one registered slot. Words aimed at a non-existent output are accepted and dropped.
module crossbar_rr_arb_seq #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_INPUT_DATA  = 8,
    parameter int NUM_OUTPUT_DATA = 4,
    localparam int DEST_WIDTH = (NUM_OUTPUT_DATA > 1) ? $clog2(NUM_OUTPUT_DATA) : 1,
    localparam int SRC_WIDTH  = (NUM_INPUT_DATA > 1) ? $clog2(NUM_INPUT_DATA) : 1
) (
    input  logic                                  CLK,
    input  logic                                  rst,
    input  logic                                  i_en,
    input  logic [NUM_INPUT_DATA-1:0]             i_valid,
    input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0]  i_data_bus,
    input  logic [NUM_INPUT_DATA*DEST_WIDTH-1:0]  i_dest,
    output logic [NUM_INPUT_DATA-1:0]             o_in_ready,
    output logic [NUM_OUTPUT_DATA-1:0]            o_valid,
    output logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0] o_data_bus,
    output logic [NUM_OUTPUT_DATA*SRC_WIDTH-1:0]  o_src_id,
    input  logic [NUM_OUTPUT_DATA-1:0]            i_out_ready
);

    localparam logic [DEST_WIDTH:0] NUM_OUT_W = (DEST_WIDTH+1)'(NUM_OUTPUT_DATA);
    localparam logic [SRC_WIDTH:0]  NUM_IN_W  = (SRC_WIDTH+1)'(NUM_INPUT_DATA);
    localparam logic [SRC_WIDTH-1:0] LAST_SRC = SRC_WIDTH'(NUM_INPUT_DATA - 1);

    logic [NUM_INPUT_DATA-1:0]  active;
    logic [NUM_INPUT_DATA-1:0]  drop_vec;
    logic [DEST_WIDTH-1:0]      dest_arr [NUM_INPUT_DATA];
    logic [NUM_INPUT_DATA-1:0]  gnt_vec  [NUM_OUTPUT_DATA];

    // Input side: decode the destination and collect the accept from whichever output granted us.
    for (genvar gi = 0; gi < NUM_INPUT_DATA; gi++) begin : g_in
        logic hit;

        assign dest_arr[gi] = i_dest[gi*DEST_WIDTH +: DEST_WIDTH];
        assign active[gi]   = i_en & i_valid[gi] & ~rst;
        assign drop_vec[gi] = active[gi] & ({1'b0, dest_arr[gi]} >= NUM_OUT_W);

        always_comb begin
            hit = drop_vec[gi];
            for (int j = 0; j < NUM_OUTPUT_DATA; j++) begin
                hit = hit | gnt_vec[j][gi];
            end
        end

        assign o_in_ready[gi] = hit;
    end

    // Output side: one arbiter plus one slot per output lane.
    for (genvar go = 0; go < NUM_OUTPUT_DATA; go++) begin : g_out
        logic [NUM_INPUT_DATA-1:0] req;
        logic [NUM_INPUT_DATA-1:0] gnt_onehot;
        logic                      can_load;
        logic                      gnt_any;
        logic [SRC_WIDTH-1:0]      gnt_idx;
        logic [SRC_WIDTH:0]        cand;
        logic                      valid_q, valid_d;
        logic [DATA_WIDTH-1:0]     data_q, data_d;
        logic [SRC_WIDTH-1:0]      src_q, src_d;
        logic [SRC_WIDTH-1:0]      ptr_q, ptr_d;

        always_comb begin
            req = '0;
            for (int k = 0; k < NUM_INPUT_DATA; k++) begin
                req[k] = active[k] & (dest_arr[k] == DEST_WIDTH'(go));
            end
        end

        // Cyclic search starting at the pointer; first requester found wins.
        always_comb begin
            can_load = ~valid_q | i_out_ready[go];
            gnt_any  = 1'b0;
            gnt_idx  = '0;
            cand     = '0;
            for (int off = 0; off < NUM_INPUT_DATA; off++) begin
                cand = {1'b0, ptr_q} + (SRC_WIDTH+1)'(off);
                if (cand >= NUM_IN_W) begin
                    cand = cand - NUM_IN_W;
                end
                if (can_load && !gnt_any && req[cand[SRC_WIDTH-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand[SRC_WIDTH-1:0];
                end
            end
        end

        always_comb begin
            gnt_onehot = '0;
            if (gnt_any) begin
                gnt_onehot[gnt_idx] = 1'b1;
            end
        end

        assign gnt_vec[go] = gnt_onehot;

        // A load takes priority over a pop so the slot can turn over every cycle.
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            src_d   = src_q;
            ptr_d   = ptr_q;
            if (gnt_any) begin
                valid_d = 1'b1;
                data_d  = i_data_bus[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                src_d   = gnt_idx;
                ptr_d   = (gnt_idx == LAST_SRC) ? '0 : gnt_idx + SRC_WIDTH'(1);
            end else if (valid_q && i_out_ready[go]) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge CLK) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                src_q   <= '0;
                ptr_q   <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
                src_q   <= src_d;
                ptr_q   <= ptr_d;
            end
        end

        assign o_valid[go]                                = valid_q;
        assign o_data_bus[go*DATA_WIDTH +: DATA_WIDTH]    = data_q;
        assign o_src_id[go*SRC_WIDTH +: SRC_WIDTH]        = src_q;
    end

endmodule

// File: tb/tb_crossbar_rr_arb_seq.sv
// Self-checking bench for crossbar_rr_arb_seq: directed scenarios plus a randomized run
// against a behavioural per-output round-robin model. A second 3-output instance covers dropped destinations.
module tb_crossbar_rr_arb_seq;
    localparam int DW     = 32;
    localparam int NI     = 8;
    localparam int NO     = 4;
    localparam int NO3    = 3;
    localparam int DEST_W = 2;
    localparam int SRC_W  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               en;
    logic [NI-1:0]      valid;
    logic [NI*DW-1:0]   data_bus;
    logic [NI*DEST_W-1:0] dest_bus;
    logic [NO-1:0]      out_ready;
    logic [NI-1:0]      in_ready;
    logic [NO-1:0]      o_valid;
    logic [NO*DW-1:0]   o_data;
    logic [NO*SRC_W-1:0] o_src;

    logic               b_en;
    logic [NI-1:0]      b_valid;
    logic [NI*DW-1:0]   b_data;
    logic [NI*DEST_W-1:0] b_dest;
    logic [NO3-1:0]     b_out_ready;
    logic [NI-1:0]      b_in_ready;
    logic [NO3-1:0]     b_ovalid;
    logic [NO3*DW-1:0]  b_odata;
    logic [NO3*SRC_W-1:0] b_osrc;

    int tests_run    = 0;
    int tests_failed = 0;

    int           m_ptr   [NO];
    logic         m_valid [NO];
    logic [31:0]  m_data  [NO];
    int           m_src   [NO];
    logic [NI-1:0] exp_ready;

    crossbar_rr_arb_seq #(.DATA_WIDTH(DW), .NUM_INPUT_DATA(NI), .NUM_OUTPUT_DATA(NO)) dut (
        .CLK(clk), .rst(rst), .i_en(en), .i_valid(valid), .i_data_bus(data_bus), .i_dest(dest_bus),
        .o_in_ready(in_ready), .o_valid(o_valid), .o_data_bus(o_data), .o_src_id(o_src),
        .i_out_ready(out_ready)
    );

    crossbar_rr_arb_seq #(.DATA_WIDTH(DW), .NUM_INPUT_DATA(NI), .NUM_OUTPUT_DATA(NO3)) dut3 (
        .CLK(clk), .rst(rst), .i_en(b_en), .i_valid(b_valid), .i_data_bus(b_data), .i_dest(b_dest),
        .o_in_ready(b_in_ready), .o_valid(b_ovalid), .o_data_bus(b_odata), .o_src_id(b_osrc),
        .i_out_ready(b_out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int k, input logic v, input int d, input logic [31:0] w);
        valid[k] = v;
        dest_bus[k*DEST_W +: DEST_W] = DEST_W'(d);
        data_bus[k*DW +: DW] = w;
    endtask

    task automatic clear_inputs();
        en = 1'b1; valid = '0; data_bus = '0; dest_bus = '0; out_ready = '1;
        b_en = 1'b0; b_valid = '0; b_data = '0; b_dest = '0; b_out_ready = '1;
    endtask

    task automatic model_reset();
        for (int j = 0; j < NO; j++) begin
            m_ptr[j] = 0; m_valid[j] = 1'b0; m_data[j] = '0; m_src[j] = 0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // Behavioural model: predicts this cycle's accepts and advances the slots to their post-edge state.
    task automatic model_eval();
        int granted;
        int k;
        exp_ready = '0;
        for (int j = 0; j < NO; j++) begin
            granted = -1;
            if (en && (!m_valid[j] || out_ready[j])) begin
                for (int off = 0; off < NI; off++) begin
                    k = (m_ptr[j] + off) % NI;
                    if (granted < 0 && valid[k] && int'(dest_bus[k*DEST_W +: DEST_W]) == j)
                        granted = k;
                end
            end
            if (granted >= 0) begin
                exp_ready[granted] = 1'b1;
                m_valid[j] = 1'b1;
                m_data[j]  = data_bus[granted*DW +: DW];
                m_src[j]   = granted;
                m_ptr[j]   = (granted + 1) % NI;
            end else if (m_valid[j] && out_ready[j]) begin
                m_valid[j] = 1'b0;
            end
        end
        for (int kk = 0; kk < NI; kk++) begin
            if (en && valid[kk] && int'(dest_bus[kk*DEST_W +: DEST_W]) >= NO) exp_ready[kk] = 1'b1;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        valid = NI'($urandom);
        out_ready = NO'($urandom);
        for (int k = 0; k < NI; k++) begin
            data_bus[k*DW +: DW] = $urandom;
            dest_bus[k*DEST_W +: DEST_W] = DEST_W'($urandom_range(0, 3));
        end
        #1;
        tests_run++;
        if (in_ready !== '0) begin tests_failed++; $display("FAIL reset_in_ready_early: got %h expected 0", in_ready); end
        tick();
        tick();
        tests_run++;
        if (o_valid !== '0) begin tests_failed++; $display("FAIL reset_o_valid: got %h expected 0", o_valid); end
        tests_run++;
        if (o_data !== '0) begin tests_failed++; $display("FAIL reset_o_data: got %h expected 0", o_data); end
        tests_run++;
        if (o_src !== '0) begin tests_failed++; $display("FAIL reset_o_src: got %h expected 0", o_src); end
        tests_run++;
        if (in_ready !== '0) begin tests_failed++; $display("FAIL reset_in_ready: got %h expected 0", in_ready); end
        tests_run++;
        if (b_ovalid !== '0) begin tests_failed++; $display("FAIL reset_b_o_valid: got %h expected 0", b_ovalid); end
        rst = 1'b0;
        valid = '0;
        for (int c = 0; c < 3; c++) tick();
        tests_run++;
        if (o_valid !== '0 || o_data !== '0 || o_src !== '0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got valid %h data %h src %h expected all 0", o_valid, o_data, o_src);
        end
        model_reset();
    endtask

    task automatic test_permutation();
        do_reset();
        set_lane(0, 1'b1, 3, 32'hA0);
        set_lane(1, 1'b1, 2, 32'hA1);
        set_lane(2, 1'b1, 1, 32'hA2);
        set_lane(3, 1'b1, 0, 32'hA3);
        #1;
        tests_run++;
        if (in_ready !== 8'h0F) begin tests_failed++; $display("FAIL perm_in_ready: got %h expected 0f", in_ready); end
        tick();
        valid = '0;
        tests_run++;
        if (o_valid !== 4'hF) begin tests_failed++; $display("FAIL perm_o_valid: got %h expected f", o_valid); end
        tests_run++;
        if (o_data !== {32'hA0, 32'hA1, 32'hA2, 32'hA3}) begin
            tests_failed++; $display("FAIL perm_o_data: got %h expected a0/a1/a2/a3 on lanes 3..0", o_data);
        end
        tests_run++;
        if (o_src !== {3'd0, 3'd1, 3'd2, 3'd3}) begin
            tests_failed++; $display("FAIL perm_o_src: got %h expected %h", o_src, {3'd0, 3'd1, 3'd2, 3'd3});
        end
        tick();
        tests_run++;
        if (o_valid !== 4'h0 || o_data !== {32'hA0, 32'hA1, 32'hA2, 32'hA3}) begin
            tests_failed++; $display("FAIL perm_pop_hold: got valid %h data %h expected valid 0 data held", o_valid, o_data);
        end
    endtask

    task automatic test_round_robin();
        int g;
        logic [NI-1:0] er;
        do_reset();
        for (int k = 0; k < NI; k++) set_lane(k, 1'b1, 1, 32'h10 + k);
        for (int c = 0; c < NI + 1; c++) begin
            g = c % NI;
            er = NI'(1) << g;
            #1;
            tests_run++;
            if (in_ready !== er) begin tests_failed++; $display("FAIL rr_in_ready cycle %0d: got %h expected %h", c, in_ready, er); end
            tick();
            tests_run++;
            if (o_valid !== 4'b0010 || o_src[SRC_W +: SRC_W] !== SRC_W'(g) || o_data[DW +: DW] !== 32'h10 + g) begin
                tests_failed++;
                $display("FAIL rr_output cycle %0d: got valid %h src %0d data %h expected valid 2 src %0d data %h",
                         c, o_valid, o_src[SRC_W +: SRC_W], o_data[DW +: DW], g, 32'h10 + g);
            end
        end
        valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        logic ev;
        int es;
        int nxt;
        logic [NI-1:0] er;
        do_reset();
        for (int k = 0; k < NI; k++) set_lane(k, 1'b1, 1, 32'h10 + k);
        ev = 1'b0; es = 0; nxt = 0;
        for (int c = 0; c < 11; c++) begin
            out_ready = (c >= 3 && c <= 6) ? 4'b1101 : 4'b1111;
            #1;
            if (!ev || out_ready[1]) begin
                er = NI'(1) << nxt; ev = 1'b1; es = nxt; nxt = (nxt + 1) % NI;
            end else begin
                er = '0;
            end
            tests_run++;
            if (in_ready !== er) begin tests_failed++; $display("FAIL bp_in_ready cycle %0d: got %h expected %h", c, in_ready, er); end
            tick();
            tests_run++;
            if (o_valid[1] !== ev || o_src[SRC_W +: SRC_W] !== SRC_W'(es) || o_data[DW +: DW] !== 32'h10 + es) begin
                tests_failed++;
                $display("FAIL bp_output cycle %0d: got valid %b src %0d data %h expected valid %b src %0d data %h",
                         c, o_valid[1], o_src[SRC_W +: SRC_W], o_data[DW +: DW], ev, es, 32'h10 + es);
            end
        end
        valid = '0;
        tick();
    endtask

    task automatic test_enable();
        do_reset();
        for (int k = 0; k < NI; k++) set_lane(k, 1'b1, 2, 32'h10 + k);
        #1;
        tests_run++;
        if (in_ready !== 8'h01) begin tests_failed++; $display("FAIL en_first_in_ready: got %h expected 01", in_ready); end
        tick();
        tests_run++;
        if (o_valid !== 4'b0100 || o_src[2*SRC_W +: SRC_W] !== 3'd0) begin
            tests_failed++; $display("FAIL en_first_output: got valid %h src %0d expected valid 4 src 0", o_valid, o_src[2*SRC_W +: SRC_W]);
        end
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++;
            if (in_ready !== '0) begin tests_failed++; $display("FAIL en_low_in_ready cycle %0d: got %h expected 0", c, in_ready); end
            tick();
            tests_run++;
            if (o_valid !== 4'b0000 || o_data[2*DW +: DW] !== 32'h10) begin
                tests_failed++; $display("FAIL en_low_drain cycle %0d: got valid %h data %h expected valid 0 data 10", c, o_valid, o_data[2*DW +: DW]);
            end
        end
        en = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 8'h02) begin tests_failed++; $display("FAIL en_resume_in_ready: got %h expected 02", in_ready); end
        tick();
        tests_run++;
        if (o_valid !== 4'b0100 || o_src[2*SRC_W +: SRC_W] !== 3'd1 || o_data[2*DW +: DW] !== 32'h11) begin
            tests_failed++; $display("FAIL en_resume_output: got valid %h src %0d data %h expected valid 4 src 1 data 11",
                                     o_valid, o_src[2*SRC_W +: SRC_W], o_data[2*DW +: DW]);
        end
        valid = '0;
        tick();
    endtask

    task automatic test_full_rate();
        logic [31:0] q [$];
        logic [31:0] expw;
        int run;
        do_reset();
        run = 0;
        for (int i = 1; i <= 32; i++) begin
            set_lane(2, 1'b1, 0, i);
            #1;
            tests_run++;
            if (in_ready !== 8'h04) begin tests_failed++; $display("FAIL fr_in_ready word %0d: got %h expected 04", i, in_ready); end
            q.push_back(32'(i));
            tick();
            if (o_valid[0] && q.size() > 0) begin
                expw = q.pop_front();
                run++;
                tests_run++;
                if (o_data[0 +: DW] !== expw || o_src[0 +: SRC_W] !== 3'd2) begin
                    tests_failed++; $display("FAIL fr_word %0d: got data %h src %0d expected data %h src 2", i, o_data[0 +: DW], o_src[0 +: SRC_W], expw);
                end
            end
        end
        tests_run++;
        if (run !== 32) begin tests_failed++; $display("FAIL fr_run_length: got %0d expected 32", run); end
        valid = '0;
        tick();
        tests_run++;
        if (o_valid[0] !== 1'b0) begin tests_failed++; $display("FAIL fr_drain: got valid %b expected 0", o_valid[0]); end
    endtask

    task automatic test_random();
        logic [NI-1:0] hold;
        logic [NO-1:0] ev;
        logic [NO*DW-1:0] ed;
        logic [NO*SRC_W-1:0] es;
        do_reset();
        hold = '0;
        for (int c = 0; c < 300; c++) begin
            en = ($urandom_range(0, 9) != 0);
            for (int k = 0; k < NI; k++) begin
                if (!hold[k]) begin
                    valid[k] = 1'($urandom_range(0, 1));
                    dest_bus[k*DEST_W +: DEST_W] = DEST_W'($urandom_range(0, NO - 1));
                    data_bus[k*DW +: DW] = $urandom;
                end
            end
            out_ready = NO'($urandom);
            #1;
            model_eval();
            tests_run++;
            if (in_ready !== exp_ready) begin tests_failed++; $display("FAIL rand_in_ready cycle %0d: got %h expected %h", c, in_ready, exp_ready); end
            hold = valid & ~exp_ready;
            tick();
            for (int j = 0; j < NO; j++) begin
                ev[j] = m_valid[j];
                ed[j*DW +: DW] = m_data[j];
                es[j*SRC_W +: SRC_W] = SRC_W'(m_src[j]);
            end
            tests_run++;
            if (o_valid !== ev) begin tests_failed++; $display("FAIL rand_o_valid cycle %0d: got %h expected %h", c, o_valid, ev); end
            tests_run++;
            if (o_data !== ed) begin tests_failed++; $display("FAIL rand_o_data cycle %0d: got %h expected %h", c, o_data, ed); end
            tests_run++;
            if (o_src !== es) begin tests_failed++; $display("FAIL rand_o_src cycle %0d: got %h expected %h", c, o_src, es); end
        end
        valid = '0;
        tick();
    endtask

    task automatic test_bad_dest();
        do_reset();
        b_en = 1'b1;
        b_valid[5] = 1'b1; b_dest[5*DEST_W +: DEST_W] = 2'd3; b_data[5*DW +: DW] = 32'h55;
        b_valid[4] = 1'b1; b_dest[4*DEST_W +: DEST_W] = 2'd2; b_data[4*DW +: DW] = 32'h44;
        #1;
        tests_run++;
        if (b_in_ready !== 8'h30) begin tests_failed++; $display("FAIL bad_in_ready_mixed: got %h expected 30", b_in_ready); end
        tick();
        tests_run++;
        if (b_ovalid !== 3'b100 || b_odata[2*DW +: DW] !== 32'h44 || b_osrc[2*SRC_W +: SRC_W] !== 3'd4) begin
            tests_failed++; $display("FAIL bad_mixed_output: got valid %h data %h src %0d expected valid 4 data 44 src 4",
                                     b_ovalid, b_odata[2*DW +: DW], b_osrc[2*SRC_W +: SRC_W]);
        end
        b_valid = 8'h20;
        #1;
        tests_run++;
        if (b_in_ready !== 8'h20) begin tests_failed++; $display("FAIL bad_in_ready_alone: got %h expected 20", b_in_ready); end
        tick();
        tests_run++;
        if (b_ovalid !== 3'b000) begin tests_failed++; $display("FAIL bad_no_output: got %h expected 0", b_ovalid); end
        b_en = 1'b0;
        #1;
        tests_run++;
        if (b_in_ready !== 8'h00) begin tests_failed++; $display("FAIL bad_en_low: got %h expected 0", b_in_ready); end
        tick();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_permutation();
        test_round_robin();
        test_backpressure();
        test_enable();
        test_full_rate();
        test_random();
        test_bad_dest();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
